// File: rtl/normaliza_operandos_pkg.sv
// Shared definitions for the Goldschmidt divider front end: operand format,
// shift-count width, FSM state encoding and the dividend saturation value.
package normaliza_operandos_pkg;

    localparam int W    = 20;
    localparam int FRAC = 12;
    localparam int SW   = 5;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        NORMALIZA = 2'd1,
        SAIDA     = 2'd2
    } estado_t;

    localparam logic [W-1:0] SATURADO = {W{1'b1}};

endpackage

// File: rtl/normaliza_operandos.sv
// Normalizes the divisor into [0.5,1) one bit per cycle, scaling the dividend
// by the same power of two so the quotient is preserved. Flags divide-by-zero
// and dividend saturation during left shifts. Valid/ready on both sides.
module normaliza_operandos
    import normaliza_operandos_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          entrada_valida,
    output logic          entrada_pronta,
    input  logic [W-1:0]  dividendo,
    input  logic [W-1:0]  divisor,
    output logic          saida_valida,
    input  logic          saida_pronta,
    output logic [W-1:0]  dividendo_n,
    output logic [W-1:0]  divisor_n,
    output logic [SW-1:0] deslocamento,
    output logic          div_zero,
    output logic          overflow
);

    localparam logic [SW-1:0] UM = SW'(1);

    estado_t       estado_q, estado_d;
    logic [W-1:0]  dividendo_q, dividendo_d;
    logic [W-1:0]  divisor_q, divisor_d;
    logic [SW-1:0] desloc_q, desloc_d;
    logic          divzero_q, divzero_d;
    logic          ovf_q, ovf_d;

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q    <= OCIOSO;
            dividendo_q <= '0;
            divisor_q   <= '0;
            desloc_q    <= '0;
            divzero_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            dividendo_q <= dividendo_d;
            divisor_q   <= divisor_d;
            desloc_q    <= desloc_d;
            divzero_q   <= divzero_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next state and datapath: latch on accept, one shift decision per cycle, hold in SAIDA.
    always_comb begin
        estado_d       = estado_q;
        dividendo_d    = dividendo_q;
        divisor_d      = divisor_q;
        desloc_d       = desloc_q;
        divzero_d      = divzero_q;
        ovf_d          = ovf_q;
        entrada_pronta = 1'b0;
        saida_valida   = 1'b0;

        case (estado_q)
            OCIOSO: begin
                entrada_pronta = 1'b1;
                if (entrada_valida) begin
                    desloc_d  = '0;
                    ovf_d     = 1'b0;
                    divisor_d = divisor;
                    if (divisor == '0) begin
                        divzero_d   = 1'b1;
                        dividendo_d = '0;
                        estado_d    = SAIDA;
                    end else begin
                        divzero_d   = 1'b0;
                        dividendo_d = dividendo;
                        estado_d    = NORMALIZA;
                    end
                end
            end
            NORMALIZA: begin
                if (|divisor_q[W-1:FRAC]) begin
                    divisor_d   = divisor_q >> 1;
                    dividendo_d = dividendo_q >> 1;
                    desloc_d    = desloc_q + UM;
                end else if (!divisor_q[FRAC-1]) begin
                    divisor_d = divisor_q << 1;
                    desloc_d  = desloc_q - UM;
                    if (dividendo_q[W-1]) begin
                        dividendo_d = SATURADO;
                        ovf_d       = 1'b1;
                    end else begin
                        dividendo_d = dividendo_q << 1;
                    end
                end else begin
                    estado_d = SAIDA;
                end
            end
            SAIDA: begin
                saida_valida = 1'b1;
                if (saida_pronta) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign dividendo_n  = dividendo_q;
    assign divisor_n    = divisor_q;
    assign deslocamento = desloc_q;
    assign div_zero     = divzero_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_normaliza_operandos.sv
// Directed and random transactions through normaliza_operandos with a
// queue-based scoreboard of expected results and latencies.
module tb_normaliza_operandos;

    logic        clk;
    logic        rst;
    logic        entrada_valida;
    logic        entrada_pronta;
    logic [19:0] dividendo;
    logic [19:0] divisor;
    logic        saida_valida;
    logic        saida_pronta;
    logic [19:0] dividendo_n;
    logic [19:0] divisor_n;
    logic [4:0]  deslocamento;
    logic        div_zero;
    logic        overflow;

    typedef struct {
        logic [19:0] dvd;
        logic [19:0] dvs;
        logic [4:0]  desl;
        logic        dz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t fila[$];
    int   checks = 0;
    int   errors = 0;

    normaliza_operandos dut (
        .clk            (clk),
        .rst            (rst),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .dividendo      (dividendo),
        .divisor        (divisor),
        .saida_valida   (saida_valida),
        .saida_pronta   (saida_pronta),
        .dividendo_n    (dividendo_n),
        .divisor_n      (divisor_n),
        .deslocamento   (deslocamento),
        .div_zero       (div_zero),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports failures.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [19:0] dvd, input logic [19:0] dvs,
                                input logic [4:0] desl, input logic dz,
                                input logic ovf, input int lat);
        exp_t e;
        e.dvd = dvd; e.dvs = dvs; e.desl = desl; e.dz = dz; e.ovf = ovf; e.lat = lat;
        return e;
    endfunction

    // Reference: locate the divisor's leading one and apply the whole shift at once.
    function automatic exp_t modelo(input logic [19:0] a, input logic [19:0] b);
        exp_t e;
        int   p;
        int   s;
        int   n;
        e = mk(20'h0, 20'h0, 5'h0, 1'b0, 1'b0, 1);
        if (b == 20'h0) begin
            e.dz = 1'b1;
            return e;
        end
        p = 0;
        for (int i = 0; i < 20; i++) if (b[i]) p = i;
        s = p - 11;
        if (s >= 0) begin
            e.dvs = b >> s;
            e.dvd = a >> s;
            e.lat = s + 2;
        end else begin
            n = -s;
            e.dvs = b << n;
            if ((a >> (20 - n)) != 20'h0) begin
                e.ovf = 1'b1;
                e.dvd = 20'hFFFFF;
            end else begin
                e.dvd = a << n;
            end
            e.lat = n + 2;
        end
        e.desl = 5'(s);
        return e;
    endfunction

    // Offer one transaction; returns once it has been accepted and queues its expectation.
    task automatic applyStimulus(input logic [19:0] a, input logic [19:0] b, input exp_t e);
        int espera;
        espera = 0;
        while (!entrada_pronta && espera < 30) begin
            @(posedge clk); #1;
            espera++;
        end
        check("pronta_antes", 32'(entrada_pronta), 32'd1);
        dividendo      = a;
        divisor        = b;
        entrada_valida = 1'b1;
        fila.push_back(e);
        @(posedge clk); #1;
        entrada_valida = 1'b0;
    endtask

    // Wait for the result, compare against the scoreboard, hold it, then consume it.
    task automatic checkOutput(input int hold);
        exp_t e;
        int   ciclos;
        ciclos = 1;
        while (!saida_valida && ciclos < 20) begin
            @(posedge clk); #1;
            ciclos++;
        end
        check("fila", 32'(fila.size() > 0), 32'd1);
        if (fila.size() == 0) return;
        e = fila.pop_front();
        check("valida", 32'(saida_valida), 32'd1);
        check("latencia", 32'(ciclos), 32'(e.lat));
        for (int h = 0; h <= hold; h++) begin
            check("dividendo_n", 32'(dividendo_n), 32'(e.dvd));
            check("divisor_n", 32'(divisor_n), 32'(e.dvs));
            check("deslocamento", 32'(deslocamento), 32'(e.desl));
            check("div_zero", 32'(div_zero), 32'(e.dz));
            check("overflow", 32'(overflow), 32'(e.ovf));
            check("pronta_saida", 32'(entrada_pronta), 32'd0);
            check("valida_mantida", 32'(saida_valida), 32'd1);
            if (h < hold) begin
                @(posedge clk); #1;
            end
        end
        saida_pronta = 1'b1;
        @(posedge clk); #1;
        saida_pronta = 1'b0;
        check("valida_cai", 32'(saida_valida), 32'd0);
        check("pronta_volta", 32'(entrada_pronta), 32'd1);
    endtask

    initial begin
        logic [19:0] ra;
        logic [19:0] rb;
        rst            = 1'b1;
        entrada_valida = 1'b0;
        saida_pronta   = 1'b0;
        dividendo      = '0;
        divisor        = '0;
        #12;
        check("rst_pronta", 32'(entrada_pronta), 32'd1);
        check("rst_valida", 32'(saida_valida), 32'd0);
        check("rst_dividendo", 32'(dividendo_n), 32'd0);
        check("rst_divisor", 32'(divisor_n), 32'd0);
        check("rst_desl", 32'(deslocamento), 32'd0);
        check("rst_flags", 32'({div_zero, overflow}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed cases");
        applyStimulus(20'h03000, 20'h00800, mk(20'h03000, 20'h00800, 5'd0, 1'b0, 1'b0, 2));
        checkOutput(0);
        applyStimulus(20'h03000, 20'h01000, mk(20'h01800, 20'h00800, 5'd1, 1'b0, 1'b0, 3));
        checkOutput(0);
        applyStimulus(20'h12345, 20'hFFFFF, mk(20'h00123, 20'h00FFF, 5'd8, 1'b0, 1'b0, 10));
        checkOutput(0);
        applyStimulus(20'h00003, 20'h00001, mk(20'h01800, 20'h00800, 5'h15, 1'b0, 1'b0, 13));
        checkOutput(0);
        applyStimulus(20'h80000, 20'h00001, mk(20'hFFFFF, 20'h00800, 5'h15, 1'b0, 1'b1, 13));
        checkOutput(0);
        applyStimulus(20'h54321, 20'h00000, mk(20'h00000, 20'h00000, 5'd0, 1'b1, 1'b0, 1));
        checkOutput(0);
        applyStimulus(20'h03000, 20'h01000, mk(20'h01800, 20'h00800, 5'd1, 1'b0, 1'b0, 3));
        checkOutput(3);

        $display("[TB] reset during normalization");
        dividendo      = 20'h00003;
        divisor        = 20'h00001;
        entrada_valida = 1'b1;
        @(posedge clk); #1;
        entrada_valida = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_pronta", 32'(entrada_pronta), 32'd1);
        check("mid_rst_valida", 32'(saida_valida), 32'd0);
        check("mid_rst_dados", 32'(dividendo_n | divisor_n), 32'd0);
        check("mid_rst_desl", 32'(deslocamento), 32'd0);
        check("mid_rst_flags", 32'({div_zero, overflow}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(20'h00003, 20'h00001, mk(20'h01800, 20'h00800, 5'h15, 1'b0, 1'b0, 13));
        checkOutput(1);

        $display("[TB] random cases");
        for (int r = 0; r < 8; r++) begin
            ra = 20'($urandom);
            rb = 20'($urandom) >> $urandom_range(0, 19);
            applyStimulus(ra, rb, modelo(ra, rb));
            checkOutput($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
